// File: rtl/serial_operand_serializer.sv
// Operand serializer feeding a 1-bit serial adder: shifts two WIDTH-bit words out LSB-first.
// Optional macro SERIAL_OPERAND_SERIALIZER_BACK_TO_BACK_EN allows a reload on the last bit (no idle bubble).
module serial_operand_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_out,
  output logic             b_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             carry_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CW-1:0]    r_cnt;

  logic w_shift;
  logic w_last;
  logic w_accept;

  assign w_shift = (r_state == SHIFT);
  assign w_last  = w_shift && (r_cnt == LAST_IDX);

`ifdef SERIAL_OPERAND_SERIALIZER_BACK_TO_BACK_EN
  assign in_ready = !w_shift || w_last;
`else
  assign in_ready = !w_shift;
`endif

  assign w_accept = in_valid && in_ready;

  // The shift registers are fully drained by the last bit, but gate anyway so IDLE is always quiet.
  assign a_out     = w_shift & r_a_sh[0];
  assign b_out     = w_shift & r_b_sh[0];
  assign bit_valid = w_shift;
  assign bit_last  = w_last;
  assign carry_clr = !w_shift || w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last && w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else if (w_last) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer (WIDTH=8) with a serial adder and sum collector attached.
module tb_serial_operand_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic         a_out, b_out, bit_valid, bit_last, carry_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  serial_operand_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
    .bit_valid(bit_valid), .bit_last(bit_last), .carry_clr(carry_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // downstream serial adder and sum collector
  logic         c_reg;
  logic [W-1:0] acc;
  logic [W-1:0] sums[$];
  logic         s_bit;
  assign s_bit = a_out ^ b_out ^ c_reg;

  always @(posedge clk) begin
    if (rst || carry_clr) c_reg <= 1'b0;
    else if (bit_valid)   c_reg <= (a_out & b_out) | (a_out & c_reg) | (b_out & c_reg);
    if (rst) acc <= '0;
    else if (bit_valid) begin
      acc <= {s_bit, acc[W-1:1]};
      if (bit_last) sums.push_back({s_bit, acc[W-1:1]});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !in_ready; i++) step();
    chk("ready_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bit_valid; i++) step();
    chk("idle_timeout", bit_valid, 0);
  endtask

  task automatic pop_sum(input string tag, input logic [W-1:0] exp);
    if (sums.size() == 0) chk({tag, "_missing"}, 0, 1);
    else chk(tag, sums.pop_front(), exp);
  endtask

  logic [W-1:0] pat;
  int           t_hs[3];
  int           qsz;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_outs", {in_ready, bit_valid, bit_last, a_out, b_out, carry_clr}, 6'b100001);

    // basic word 0x5A + 0x3C
    send_word(8'h5A, 8'h3C);
    pat = 8'h5A;
    for (int k = 0; k < W; k++) begin
      chk("w1_a_bit", a_out, pat[k]);
      chk("w1_valid", bit_valid, 1);
      chk("w1_last", bit_last, (k == W - 1));
      chk("w1_cclr", carry_clr, (k == W - 1));
`ifdef SERIAL_OPERAND_SERIALIZER_BACK_TO_BACK_EN
      chk("w1_ready", in_ready, (k == W - 1));
`else
      chk("w1_ready", in_ready, 0);
`endif
      step();
    end
    chk("w1_done", {bit_valid, in_ready}, 2'b01);
    pop_sum("sum_5a_3c", 8'h96);

    // carry out of the first word must not leak into the second
    send_word(8'hFF, 8'h01);
    wait_idle();
    send_word(8'h00, 8'h00);
    wait_idle();
    pop_sum("sum_ff_01", 8'h00);
    pop_sum("sum_00_00", 8'h00);

    // in_valid held high across three words
    in_valid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      a_in = (w == 0) ? 8'h12 : (w == 1) ? 8'h80 : 8'h0F;
      b_in = (w == 0) ? 8'h34 : (w == 1) ? 8'h80 : 8'h01;
      for (int i = 0; i < 40 && !in_ready; i++) step();
      chk("b2b_ready_to", in_ready, 1);
      t_hs[w] = cyc;
      step();
    end
    in_valid = 1'b0;
`ifdef SERIAL_OPERAND_SERIALIZER_BACK_TO_BACK_EN
    chk("b2b_period1", t_hs[1] - t_hs[0], 8);
    chk("b2b_period2", t_hs[2] - t_hs[1], 8);
`else
    chk("b2b_period1", t_hs[1] - t_hs[0], 9);
    chk("b2b_period2", t_hs[2] - t_hs[1], 9);
`endif
    wait_idle();
    pop_sum("sum_12_34", 8'h46);
    pop_sum("sum_80_80", 8'h00);
    pop_sum("sum_0f_01", 8'h10);

    // reset in the middle of a word
    qsz = sums.size();
    send_word(8'hAA, 8'h55);
    for (int i = 0; i < 4; i++) step();
    chk("mid_at_bit4", bit_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_outs", {in_ready, bit_valid, bit_last, a_out, b_out, carry_clr}, 6'b100001);
    chk("mid_rst_nosum", sums.size(), qsz);
    send_word(8'h03, 8'h05);
    wait_idle();
    pop_sum("sum_03_05", 8'h08);

    // in_valid pulsed mid-word is ignored
    send_word(8'h21, 8'h43);
    step(); step();
    a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
    chk("pulse_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) step();
    pop_sum("sum_21_43", 8'h64);
    chk("pulse_no_reload", sums.size(), 0);
    chk("pulse_idle", bit_valid, 0);

    // long idle stretch
    for (int i = 0; i < 20; i++) begin
      chk("idle_outs", {bit_valid, a_out, b_out, carry_clr}, 4'b0001);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
